// File: rtl/hd_encoder_ctrl_pkg.sv
// Shared types for the HD encoder controller: mux selects, command opcodes
// and the controller FSM state encoding.
package pkg_hd_encoder;

    typedef enum logic [1:0] {
        OUTPUT_REG = 2'd0,
        MEMORY     = 2'd1,
        ZERO       = 2'd2
    } input_sel_t;

    typedef enum logic {
        EXTERNAL = 1'b0,
        INTERNAL = 1'b1
    } man_value_sel_t;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'd0,
        OP_LOAD   = 2'd1,
        OP_ENCODE = 2'd2,
        OP_STORE  = 2'd3
    } enc_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RD     = 3'd2,
        ST_LOAD   = 3'd3,
        ST_ENCODE = 3'd4,
        ST_STORE  = 3'd5,
        ST_DONE   = 3'd6
    } enc_state_t;

endpackage

// File: rtl/hd_encoder_ctrl.sv
// Command-driven sequencer for an HD encoder datapath: clear, load from
// memory, iterate the encoder, or store its output register to memory.
module hd_encoder_ctrl
    import pkg_hd_encoder::*;
#(
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int ITER_WIDTH     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // Handshake: a command transfers on a rising edge where cmd_valid_i and
    // cmd_ready_o are both high; ready is only offered in IDLE.
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ITER_WIDTH-1:0]     cmd_iter_i,
    input  logic                      cmd_man_sel_i,
    input  logic                      abort_i,
    output logic [1:0]                input_sel_o,
    output logic                      man_value_sel_o,
    output logic                      enc_en_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                      mem_rd_o,
    output logic                      mem_wr_o,
    output logic                      busy_o,
    output logic                      done_o
);

    enc_state_t                state_q, state_d;
    enc_op_t                   op_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [ITER_WIDTH-1:0]     cnt_q;
    man_value_sel_t            man_sel_q;

    logic accept;
    logic enc_last;

    assign accept   = (state_q == ST_IDLE) && cmd_valid_i;
    // Last ENCODE cycle: either the count is exhausted or an abort arrived.
    assign enc_last = (cnt_q == ITER_WIDTH'(1)) || abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_CLEAR;
            addr_q    <= '0;
            cnt_q     <= '0;
            man_sel_q <= EXTERNAL;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= enc_op_t'(cmd_op_i);
                addr_q    <= cmd_addr_i;
                cnt_q     <= cmd_iter_i;
                man_sel_q <= man_value_sel_t'(cmd_man_sel_i);
            end else if (state_q == ST_ENCODE && !enc_last) begin
                cnt_q <= cnt_q - ITER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (enc_op_t'(cmd_op_i))
                        OP_CLEAR:  state_d = ST_CLEAR;
                        OP_LOAD:   state_d = ST_RD;
                        OP_ENCODE: state_d = (cmd_iter_i == '0) ? ST_DONE : ST_ENCODE;
                        OP_STORE:  state_d = ST_STORE;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CLEAR:  state_d = ST_DONE;
            ST_RD:     state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_DONE;
            ST_ENCODE: state_d = enc_last ? ST_DONE : ST_ENCODE;
            ST_STORE:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore decode: outputs depend only on registered state and latched fields.
    always_comb begin
        cmd_ready_o     = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        enc_en_o        = 1'b0;
        mem_rd_o        = 1'b0;
        mem_wr_o        = 1'b0;
        input_sel_o     = ZERO;
        man_value_sel_o = EXTERNAL;
        mem_addr_o      = addr_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            ST_CLEAR: enc_en_o = 1'b1;
            ST_RD:    mem_rd_o = 1'b1;
            ST_LOAD: begin
                enc_en_o    = 1'b1;
                input_sel_o = MEMORY;
            end
            ST_ENCODE: begin
                enc_en_o        = 1'b1;
                input_sel_o     = OUTPUT_REG;
                man_value_sel_o = man_sel_q;
            end
            ST_STORE: mem_wr_o = 1'b1;
            ST_DONE:  done_o   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hd_encoder_ctrl.sv
// Directed bench for hd_encoder_ctrl: inputs driven and outputs sampled on
// the falling edge, each step checked against hand-derived values.
module tb_hd_encoder_ctrl;

    localparam int AW = 5;
    localparam int IW = 8;

    localparam logic [1:0] SEL_OREG = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [IW-1:0] cmd_iter;
    logic          cmd_man_sel;
    logic          abort;
    logic [1:0]    input_sel;
    logic          man_value_sel;
    logic          enc_en;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    hd_encoder_ctrl #(.MEM_ADDR_WIDTH(AW), .ITER_WIDTH(IW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_addr_i      (cmd_addr),
        .cmd_iter_i      (cmd_iter),
        .cmd_man_sel_i   (cmd_man_sel),
        .abort_i         (abort),
        .input_sel_o     (input_sel),
        .man_value_sel_o (man_value_sel),
        .enc_en_o        (enc_en),
        .mem_addr_o      (mem_addr),
        .mem_rd_o        (mem_rd),
        .mem_wr_o        (mem_wr),
        .busy_o          (busy),
        .done_o          (done)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output vector check: ready busy done en rd wr isel msel addr.
    task automatic outs(input string tag, input logic e_ready, input logic e_busy,
                        input logic e_done, input logic e_en, input logic e_rd,
                        input logic e_wr, input logic [1:0] e_isel,
                        input logic e_msel, input logic [AW-1:0] e_addr);
        chk({tag, ".ready"}, 32'(cmd_ready), 32'(e_ready));
        chk({tag, ".busy"},  32'(busy),      32'(e_busy));
        chk({tag, ".done"},  32'(done),      32'(e_done));
        chk({tag, ".en"},    32'(enc_en),    32'(e_en));
        chk({tag, ".rd"},    32'(mem_rd),    32'(e_rd));
        chk({tag, ".wr"},    32'(mem_wr),    32'(e_wr));
        chk({tag, ".isel"},  32'(input_sel), 32'(e_isel));
        chk({tag, ".msel"},  32'(man_value_sel), 32'(e_msel));
        chk({tag, ".addr"},  32'(mem_addr),  32'(e_addr));
    endtask

    // driver task: present a command for one accepting edge, then drop valid
    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [IW-1:0] iter, input logic msel);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_addr    = addr;
        cmd_iter    = iter;
        cmd_man_sel = msel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0;
        cmd_iter = '0; cmd_man_sel = 1'b0; abort = 1'b0;

        // reset values
        @(negedge clk);
        outs("reset", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        outs("idle0", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd0);

        // CLEAR
        send(2'd0, 5'd0, 8'd0, 1'b0);
        outs("clr.clear", 0, 1, 0, 1, 0, 0, SEL_ZERO, 0, 5'd0);
        @(negedge clk);
        outs("clr.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd0);
        @(negedge clk);
        outs("clr.idle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd0);

        // LOAD addr 17
        send(2'd1, 5'd17, 8'd0, 1'b0);
        outs("ld.rd", 0, 1, 0, 0, 1, 0, SEL_ZERO, 0, 5'd17);
        @(negedge clk);
        outs("ld.load", 0, 1, 0, 1, 0, 0, SEL_MEM, 0, 5'd17);
        @(negedge clk);
        outs("ld.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd17);
        @(negedge clk);
        outs("ld.idle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd17);

        // ENCODE iter 3, INTERNAL
        send(2'd2, 5'd0, 8'd3, 1'b1);
        outs("enc3.c1", 0, 1, 0, 1, 0, 0, SEL_OREG, 1, 5'd0);
        @(negedge clk);
        outs("enc3.c2", 0, 1, 0, 1, 0, 0, SEL_OREG, 1, 5'd0);
        @(negedge clk);
        outs("enc3.c3", 0, 1, 0, 1, 0, 0, SEL_OREG, 1, 5'd0);
        @(negedge clk);
        outs("enc3.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd0);
        @(negedge clk);
        outs("enc3.idle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd0);

        // ENCODE iter 0: straight to DONE
        send(2'd2, 5'd2, 8'd0, 1'b1);
        outs("enc0.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd2);
        @(negedge clk);
        outs("enc0.idle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd2);

        // abort ignored outside ENCODE
        abort = 1'b1;
        send(2'd0, 5'd4, 8'd0, 1'b0);
        outs("abign.clear", 0, 1, 0, 1, 0, 0, SEL_ZERO, 0, 5'd4);
        @(negedge clk);
        abort = 1'b0;
        outs("abign.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd4);
        @(negedge clk);

        // ENCODE iter 200 aborted on 4th cycle
        send(2'd2, 5'd0, 8'd200, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            outs($sformatf("abort.c%0d", i), 0, 1, 0, 1, 0, 0, SEL_OREG, 0, 5'd0);
            @(negedge clk);
        end
        abort = 1'b1;
        outs("abort.c4", 0, 1, 0, 1, 0, 0, SEL_OREG, 0, 5'd0);
        @(negedge clk);
        abort = 1'b0;
        outs("abort.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd0);
        @(negedge clk);
        outs("abort.idle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd0);

        // reset during ENCODE iteration 2
        send(2'd2, 5'd9, 8'd10, 1'b1);
        outs("rstmid.c1", 0, 1, 0, 1, 0, 0, SEL_OREG, 1, 5'd9);
        @(negedge clk);
        outs("rstmid.c2", 0, 1, 0, 1, 0, 0, SEL_OREG, 1, 5'd9);
        #2 rst = 1'b1;
        #1 outs("rstmid.async", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid.nodone%0d", i), 32'(done), 32'd0);
            chk($sformatf("rstmid.ready%0d", i), 32'(cmd_ready), 32'd1);
        end

        // back-to-back: STORE addr 3 then CLEAR with valid held high
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addr = 5'd3; cmd_iter = '0; cmd_man_sel = 1'b0;
        @(negedge clk);
        cmd_op = 2'd0;
        outs("b2b.store", 0, 1, 0, 0, 0, 1, SEL_ZERO, 0, 5'd3);
        @(negedge clk);
        outs("b2b.done", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd3);
        @(negedge clk);
        outs("b2b.idle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        outs("b2b.clear", 0, 1, 0, 1, 0, 0, SEL_ZERO, 0, 5'd3);
        @(negedge clk);
        outs("b2b.cdone", 0, 1, 1, 0, 0, 0, SEL_ZERO, 0, 5'd3);
        @(negedge clk);
        outs("b2b.cidle", 1, 0, 0, 0, 0, 0, SEL_ZERO, 0, 5'd3);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hd_encoder_ctrl.md
HD_ENCODER_CTRL -- requirements
Module: hd_encoder_ctrl

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 5: encoder-memory address width.
REQ-002 Parameter ITER_WIDTH, default 8: width of the iteration count.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid_i  input  1  command request.
REQ-007 cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high on a rising edge.
REQ-008 cmd_op_i  input  2  operation, type enc_op_t.
REQ-009 cmd_addr_i  input  MEM_ADDR_WIDTH  memory row for LOAD and STORE.
REQ-010 cmd_iter_i  input  ITER_WIDTH  iteration count for ENCODE.
REQ-011 cmd_man_sel_i  input  1  manipulator value source for ENCODE, type man_value_sel_t.
REQ-012 abort_i  input  1  request to end an ENCODE early.
REQ-013 input_sel_o  output  2  encoder input mux select, type input_sel_t (OUTPUT_REG, MEMORY, ZERO).
REQ-014 man_value_sel_o  output  1  manipulator value select (EXTERNAL, INTERNAL).
REQ-015 enc_en_o  output  1  encoder output register update enable.
REQ-016 mem_addr_o  output  MEM_ADDR_WIDTH  memory address.
REQ-017 mem_rd_o  output  1  memory read strobe; read data is valid one cycle later.
REQ-018 mem_wr_o  output  1  memory write strobe; writes the encoder output register.
REQ-019 busy_o  output  1  high in every state except IDLE.
REQ-020 done_o  output  1  one-cycle completion pulse.

Function
REQ-021 FSM states SHALL be IDLE, CLEAR, RD, LOAD, ENCODE, STORE and DONE.
REQ-022 cmd_ready_o SHALL be high only in IDLE; on acceptance, op, addr, iter and man_sel SHALL be latched into registers.
REQ-023 OP_CLEAR: IDLE->CLEAR (1 cycle: enc_en_o=1, input_sel_o=ZERO)->DONE.
REQ-024 OP_LOAD: IDLE->RD (1 cycle: mem_rd_o=1, mem_addr_o=addr)->LOAD (1 cycle: enc_en_o=1, input_sel_o=MEMORY)->DONE.
REQ-025 OP_ENCODE with iter>0: stay in ENCODE exactly iter cycles with enc_en_o=1, input_sel_o=OUTPUT_REG and man_value_sel_o=latched man_sel; then ->DONE.
REQ-026 OP_ENCODE with iter=0: IDLE->DONE directly; enc_en_o never asserted.
REQ-027 The iteration counter SHALL be ITER_WIDTH bits, load iter, decrement per ENCODE cycle, and exit when it reaches 1 (no wrap).
REQ-028 abort_i sampled high in ENCODE: the current cycle's enable SHALL still take effect, and the next state SHALL be DONE.
REQ-029 abort_i SHALL be ignored in every state other than ENCODE.
REQ-030 OP_STORE: IDLE->STORE (1 cycle: mem_wr_o=1, mem_addr_o=addr)->DONE.
REQ-031 DONE SHALL last 1 cycle with done_o=1, then go to IDLE; the next command is accepted no earlier than the cycle after DONE.
REQ-032 Outside the cycles listed above: enc_en_o, mem_rd_o and mem_wr_o SHALL be 0; input_sel_o=ZERO; man_value_sel_o=EXTERNAL; mem_addr_o holds the latched address.
REQ-033 All outputs SHALL be registered-state decodes (Moore), with no combinational path from any input to any output.

Reset
REQ-034 When rst_i is asserted, the state SHALL go to IDLE immediately, regardless of clock.
REQ-035 Reset values: cmd_ready_o=1, busy_o=0, done_o=0, enc_en_o=0, mem_rd_o=0, mem_wr_o=0, input_sel_o=ZERO, man_value_sel_o=EXTERNAL, mem_addr_o=0, counter=0.
REQ-036 Reset mid-operation SHALL abandon the operation without a done_o pulse.

Structure
REQ-037 Package pkg_hd_encoder SHALL hold input_sel_t, man_value_sel_t, the new enc_op_t {OP_CLEAR, OP_LOAD, OP_ENCODE, OP_STORE} and the FSM state enum.
REQ-038 hd_encoder_ctrl SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-039 CLEAR: after reset, a CLEAR command -> enc_en_o=1 with input_sel_o=ZERO for exactly 1 cycle, then done_o pulses on the next cycle.
REQ-040 LOAD: a LOAD command with addr=5'd17 -> mem_rd_o=1 with mem_addr_o=17 for 1 cycle, then enc_en_o=1 with input_sel_o=MEMORY for 1 cycle, then done_o.
REQ-041 ENCODE: iter=3 with man_sel=INTERNAL -> exactly 3 enc_en_o cycles with input_sel_o=OUTPUT_REG and man_value_sel_o=INTERNAL, then done_o; iter=0 -> done_o 1 cycle after acceptance and no enc_en_o.
REQ-042 Abort: iter=200 with abort_i raised on the 4th ENCODE cycle -> 4 enc_en_o cycles total, then done_o, then cmd_ready_o=1.
REQ-043 Reset mid-op: rst_i asserted during ENCODE iteration 2 -> all outputs return to reset values immediately and no done_o pulse occurs.
REQ-044 Back-to-back: cmd_valid_i held high for STORE(addr=3) then CLEAR -> second command accepted only after DONE; mem_wr_o=1 with mem_addr_o=3 for exactly 1 cycle.
